// File: rtl/rom_arbiter_pkg.sv
// Shared types and defaults for the PRG/CHR ROM arbiter.
//   Provides the FSM state encoding, the requester (owner) encoding,
//   the mapper-side address width and the default unified memory map.
package rom_arbiter_pkg;

  localparam int unsigned ROM_AW_DEFAULT   = 22;
  localparam int unsigned MAP_AW           = 21;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT  = 255;
  localparam logic [21:0] CHR_BASE_DEFAULT = 22'h200000;
  localparam logic [7:0]  TIMEOUT_DATA     = 8'hFF;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_PRG = 1'b0,
    OWNER_CHR = 1'b1
  } owner_t;

endpackage

// File: rtl/rom_arbiter.sv
// Serialises the mapper's PRG-ROM and CHR-ROM read ports onto one shared
// read-only ROM port with round-robin arbitration and a per-access watchdog.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   promaddr/promreq            PRG request (level, held until promack)
//   promdata/promack            PRG read data and one-cycle completion pulse
//   cromaddr/cromreq            CHR request (level, held until cromack)
//   cromdata/cromack            CHR read data and one-cycle completion pulse
//   rom_addr/rom_rd             unified ROM address and read command
//   rom_gnt                     memory accepted the command this cycle
//   rom_rdata/rom_valid         memory read data and its valid pulse
//   timeout_err                 sticky flag: an access hit the watchdog limit
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned     AW       = ROM_AW_DEFAULT,
  parameter logic [AW-1:0]   CHR_BASE = AW'(CHR_BASE_DEFAULT),
  parameter int unsigned     TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MAP_AW-1:0] promaddr,
  input  logic              promreq,
  output logic [DATA_W-1:0] promdata,
  output logic              promack,
  input  logic [MAP_AW-1:0] cromaddr,
  input  logic              cromreq,
  output logic [DATA_W-1:0] cromdata,
  output logic              cromack,
  output logic [AW-1:0]     rom_addr,
  output logic              rom_rd,
  input  logic              rom_gnt,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic              rom_valid,
  output logic              timeout_err
);

  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              last_chr_q, last_chr_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic [AW-1:0]     rom_addr_d;
  logic              rom_rd_d;
  logic              promack_d, cromack_d;
  logic [DATA_W-1:0] promdata_d, cromdata_d;
  logic              timeout_err_d;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_PRG;
      last_chr_q  <= 1'b0;
      wdog_q      <= '0;
      rom_addr    <= '0;
      rom_rd      <= 1'b0;
      promack     <= 1'b0;
      cromack     <= 1'b0;
      promdata    <= '0;
      cromdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_chr_q  <= last_chr_d;
      wdog_q      <= wdog_d;
      rom_addr    <= rom_addr_d;
      rom_rd      <= rom_rd_d;
      promack     <= promack_d;
      cromack     <= cromack_d;
      promdata    <= promdata_d;
      cromdata    <= cromdata_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_chr_d    = last_chr_q;
    wdog_d        = wdog_q;
    rom_addr_d    = rom_addr;
    rom_rd_d      = rom_rd;
    promack_d     = 1'b0;
    cromack_d     = 1'b0;
    promdata_d    = promdata;
    cromdata_d    = cromdata;
    timeout_err_d = timeout_err;
    cap_en        = 1'b0;
    cap_data      = rom_rdata;

    case (state_q)
      ARB_IDLE: begin
        wdog_d = '0;
        if (promreq || cromreq) begin
          // Contention goes to whichever side was not served last.
          if (promreq && cromreq) owner_d = last_chr_q ? OWNER_PRG : OWNER_CHR;
          else                    owner_d = cromreq ? OWNER_CHR : OWNER_PRG;
          rom_addr_d = (owner_d == OWNER_CHR) ? CHR_BASE + AW'(cromaddr) : AW'(promaddr);
          rom_rd_d   = 1'b1;
          state_d    = ARB_ISSUE;
        end
      end

      ARB_ISSUE, ARB_WAIT: begin
        // Data accompanying the grant counts as completion.
        if (rom_valid && (state_q == ARB_WAIT || rom_gnt)) begin
          rom_rd_d = 1'b0;
          cap_en   = 1'b1;
          state_d  = ARB_ACK;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          rom_rd_d      = 1'b0;
          cap_en        = 1'b1;
          cap_data      = TIMEOUT_DATA;
          timeout_err_d = 1'b1;
          state_d       = ARB_ACK;
        end else begin
          wdog_d = wdog_q + WDW'(1);
          if (state_q == ARB_ISSUE && rom_gnt) begin
            rom_rd_d = 1'b0;
            state_d  = ARB_WAIT;
          end
        end
      end

      ARB_ACK: begin
        last_chr_d = (owner_q == OWNER_CHR);
        state_d    = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase

    // Completion loads the owner's data register and raises its ack for the ACK cycle.
    if (cap_en) begin
      if (owner_q == OWNER_CHR) begin
        cromdata_d = cap_data;
        cromack_d  = 1'b1;
      end else begin
        promdata_d = cap_data;
        promack_d  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized two-requester run against a
// transaction-level reference (address map, memory contents, fairness rule).
module tb_rom_arbiter;

  logic        clk;
  logic        reset;
  logic [20:0] promaddr, cromaddr;
  logic        promreq, cromreq;
  logic [7:0]  promdata, cromdata;
  logic        promack, cromack;
  logic [21:0] rom_addr;
  logic        rom_rd, rom_gnt, rom_valid;
  logic [7:0]  rom_rdata;
  logic        timeout_err;

  rom_arbiter dut (
    .clk(clk), .reset(reset),
    .promaddr(promaddr), .promreq(promreq), .promdata(promdata), .promack(promack),
    .cromaddr(cromaddr), .cromreq(cromreq), .cromdata(cromdata), .cromack(cromack),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_gnt(rom_gnt),
    .rom_rdata(rom_rdata), .rom_valid(rom_valid), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference memory contents and address map.
  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  function automatic logic [21:0] map_addr(input bit chr, input logic [20:0] a);
    int unsigned v;
    v = 32'(a) + (chr ? 32'd2097152 : 32'd0);
    return 22'(v % 32'd4194304);
  endfunction

  // Memory model: grant after gnt_dly cycles of rom_rd (-1: never),
  // valid val_dly cycles after grant (0: same cycle, -1: never).
  int          gnt_dly = 0, val_dly = 1;
  bit          mem_rand = 0, mem_fixed_en = 0;
  logic [7:0]  mem_fixed = 8'h00;
  bit          rd_seen = 0, vpend = 0;
  int          wcnt = 0, vcnt = 0, gt = 0, vt = 0;
  logic [7:0]  vdata = 8'h00, mdata = 8'h00;

  initial begin
    rom_gnt = 1'b0; rom_valid = 1'b0; rom_rdata = 8'h00;
    forever begin
      @(negedge clk);
      rom_gnt = 1'b0; rom_valid = 1'b0; rom_rdata = 8'($urandom);
      if (vpend) begin
        if (vcnt == 0) begin rom_valid = 1'b1; rom_rdata = vdata; vpend = 0; end
        else vcnt--;
      end
      if (rom_rd) begin
        if (!rd_seen) begin
          rd_seen = 1; wcnt = 0;
          gt = mem_rand ? int'($urandom_range(0, 3)) : gnt_dly;
          vt = mem_rand ? int'($urandom_range(0, 4)) : val_dly;
        end
        if (gt >= 0 && wcnt == gt) begin
          rom_gnt = 1'b1;
          mdata = mem_fixed_en ? mem_fixed : mem_byte(rom_addr);
          if (vt == 0) begin rom_valid = 1'b1; rom_rdata = mdata; end
          else if (vt > 0) begin vpend = 1; vcnt = vt - 1; vdata = mdata; end
        end
        wcnt++;
      end else begin
        rd_seen = 0;
      end
    end
  end

  // Monitor: rom port stability, ack shape, ack order, round-robin fairness.
  bit          prev_rd = 0, prev_pack = 0, prev_cack = 0;
  logic [21:0] prev_addr = '0, rd_addr = '0;
  int          rd_rise = 0, rd_len = 0, n_pack = 0, n_cack = 0, last_ack_cyc = 0;
  bit          ack_q[$];
  bit          req_act[2];
  int          req_rise[2];
  int          bypass[2];

  task automatic ack_seen(input bit s);
    bit o;
    o = !s;
    if (s) n_cack++; else n_pack++;
    last_ack_cyc = cyc;
    ack_q.push_back(s);
    // A side already waiting when this access was granted may be passed over at most once.
    if (req_act[o] && req_rise[o] < rd_rise) begin
      bypass[o]++;
      chk("fair_bypass_over_1", 32'(bypass[o] > 1), 0);
    end
    bypass[s] = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rom_rd && !prev_rd) begin rd_rise = cyc; rd_addr = rom_addr; rd_len = 0; end
      if (rom_rd && prev_rd) chk("rom_addr_stable", 32'(rom_addr), 32'(prev_addr));
      if (rom_rd) rd_len++;
      if (promack) begin
        chk("prg_ack_width", 32'(prev_pack), 0);
        chk("one_ack_at_a_time", 32'(cromack), 0);
        ack_seen(1'b0);
      end
      if (cromack) begin
        chk("chr_ack_width", 32'(prev_cack), 0);
        ack_seen(1'b1);
      end
      prev_rd = rom_rd; prev_addr = rom_addr; prev_pack = promack; prev_cack = cromack;
    end
  end

  // Requester: raise level request, hold until ack, drop.
  task automatic do_req(input bit chr, input logic [20:0] addr, input int max_cyc,
                        output logic [7:0] data, output bit got);
    int n;
    got = 0; data = 8'h00; n = 0;
    @(negedge clk);
    if (chr) begin cromaddr = addr; cromreq = 1'b1; end
    else     begin promaddr = addr; promreq = 1'b1; end
    req_act[chr] = 1'b1; req_rise[chr] = cyc;
    while (!got && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (chr ? cromack : promack) begin
        got = 1;
        data = chr ? cromdata : promdata;
      end
    end
    if (chr) cromreq = 1'b0; else promreq = 1'b0;
    req_act[chr] = 1'b0;
  endtask

  task automatic req_check(input bit chr, input logic [20:0] addr, input string name);
    logic [7:0] d;
    bit g;
    do_req(chr, addr, 600, d, g);
    chk({name, "_ack"}, 32'(g), 1);
    if (g) chk({name, "_data"}, 32'(d), 32'(mem_byte(map_addr(chr, addr))));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; promreq = 1'b0; cromreq = 1'b0;
    req_act[0] = 0; req_act[1] = 0; bypass[0] = 0; bypass[1] = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          chr;
    logic [20:0] addr;
    int          gnt;
    int          val;
    logic [7:0]  rdata;
    logic [21:0] exp_addr;
    logic [7:0]  exp_data;
    int          exp_lat;
    int          exp_rdlen;
    bit          exp_terr;
  } vec_t;

  localparam int NV = 9;
  vec_t        vecs[NV];
  bit          exp_order[6];
  int          pa, ca, wn;
  logic [7:0]  d;
  bit          g;

  initial begin
    // chr addr gnt val rdata | exp rom_addr, data, ack-after-rd-rise, rd cycles, sticky err
    vecs[0] = '{1'b0, 21'h000123,  0,  1, 8'hA5, 22'h000123, 8'hA5,   2,   1, 1'b0};
    vecs[1] = '{1'b1, 21'h001FFF,  0,  1, 8'h3C, 22'h201FFF, 8'h3C,   2,   1, 1'b0};
    vecs[2] = '{1'b0, 21'h1FFFFF,  0,  0, 8'h5A, 22'h1FFFFF, 8'h5A,   1,   1, 1'b0};
    vecs[3] = '{1'b1, 21'h1FFFFF, 10,  5, 8'h81, 22'h3FFFFF, 8'h81,  16,  11, 1'b0};
    vecs[4] = '{1'b0, 21'h000000,  3,  2, 8'h00, 22'h000000, 8'h00,   6,   4, 1'b0};
    vecs[5] = '{1'b1, 21'h000000,  1,  3, 8'hFF, 22'h200000, 8'hFF,   5,   2, 1'b0};
    vecs[6] = '{1'b0, 21'h00ABCD,  0, -1, 8'h11, 22'h00ABCD, 8'hFF, 255,   1, 1'b1};
    vecs[7] = '{1'b1, 21'h000010,  0,  1, 8'h77, 22'h200010, 8'h77,   2,   1, 1'b1};
    vecs[8] = '{1'b0, 21'h000042, -1, -1, 8'h22, 22'h000042, 8'hFF, 255, 255, 1'b1};
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; promreq = 1'b0; cromreq = 1'b0; promaddr = '0; cromaddr = '0;
    req_act[0] = 0; req_act[1] = 0; req_rise[0] = 0; req_rise[1] = 0;
    bypass[0] = 0; bypass[1] = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'({promack, cromack, rom_rd, timeout_err}), 0);
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_data", 32'({promdata, cromdata}), 0);
    reset = 1'b0;

    // Directed single-requester vectors.
    mem_fixed_en = 1;
    for (int i = 0; i < NV; i++) begin
      gnt_dly = vecs[i].gnt; val_dly = vecs[i].val; mem_fixed = vecs[i].rdata;
      pa = n_pack; ca = n_cack;
      do_req(vecs[i].chr, vecs[i].addr, 400, d, g);
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), 32'(g), 1);
      chk($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_rom_addr", i), 32'(rd_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_latency", i), 32'(last_ack_cyc - rd_rise), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rd_cycles", i), 32'(rd_len), 32'(vecs[i].exp_rdlen));
      chk($sformatf("v%0d_prg_acks", i), 32'(n_pack - pa), vecs[i].chr ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_chr_acks", i), 32'(n_cack - ca), vecs[i].chr ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_timeout_err", i), 32'(timeout_err), 32'(vecs[i].exp_terr));
    end
    mem_fixed_en = 0;
    gnt_dly = 0; val_dly = 1;

    // Simultaneous requests re-raised three times: strict alternation starting with CHR.
    do_reset();
    chk("reset_clears_timeout_err", 32'(timeout_err), 0);
    ack_q.delete();
    fork
      for (int k = 0; k < 3; k++) req_check(1'b0, 21'(32'h00400 + k), "rr_prg");
      for (int k = 0; k < 3; k++) req_check(1'b1, 21'(32'h1A000 + k), "rr_chr");
    join
    @(negedge clk);
    chk("rr_ack_count", 32'(ack_q.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < ack_q.size()) chk($sformatf("rr_order_%0d", i), 32'(ack_q[i]), 32'(exp_order[i]));

    // Request dropped early and address changed after grant: access still completes.
    pa = n_pack;
    @(negedge clk); promaddr = 21'h012AB; promreq = 1'b1;
    @(negedge clk); promreq = 1'b0; promaddr = 21'h1F0F0;
    g = 0; wn = 0;
    while (!g && wn < 20) begin
      @(negedge clk); wn++;
      if (promack) begin g = 1; d = promdata; end
    end
    chk("early_drop_ack", 32'(g), 1);
    chk("early_drop_data", 32'(d), 32'(mem_byte(map_addr(1'b0, 21'h012AB))));
    chk("early_drop_rom_addr", 32'(rd_addr), 32'(map_addr(1'b0, 21'h012AB)));
    repeat (6) @(negedge clk);
    chk("early_drop_single_ack", 32'(n_pack - pa), 1);
    chk("early_drop_no_reissue", 32'(rom_rd), 0);

    // Randomized two-requester traffic with random memory timing.
    mem_rand = 1;
    pa = n_pack + n_cack;
    fork
      for (int k = 0; k < 20; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req_check(1'b0, 21'($urandom), "rand_prg");
      end
      for (int k = 0; k < 20; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req_check(1'b1, 21'($urandom), "rand_chr");
      end
    join
    @(negedge clk);
    mem_rand = 0;
    chk("rand_total_acks", 32'(n_pack + n_cack - pa), 40);

    // Reset during WAIT, stray valid afterwards, then normal service.
    gnt_dly = 0; val_dly = 3;
    pa = n_pack + n_cack;
    @(negedge clk); promaddr = 21'h0BEEF; promreq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_rom_addr", 32'(rom_addr), 32'(map_addr(1'b0, 21'h0BEEF)));
    chk("pre_reset_rd_dropped", 32'(rom_rd), 0);
    reset = 1'b1; promreq = 1'b0;
    #1;
    chk("midreset_ctrl", 32'({promack, cromack, rom_rd, timeout_err}), 0);
    chk("midreset_rom_addr", 32'(rom_addr), 0);
    chk("midreset_data", 32'({promdata, cromdata}), 0);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midreset_no_ack", 32'(n_pack + n_cack - pa), 0);
    chk("midreset_idle_rd", 32'(rom_rd), 0);
    val_dly = 1;
    req_check(1'b0, 21'h0BEEF, "post_reset");
    @(negedge clk);
    chk("post_reset_rom_addr", 32'(rd_addr), 32'(map_addr(1'b0, 21'h0BEEF)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
